mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
//  Initiator side of the word-wide memory interface (clk, wr, addr, data_in -> data_out, data_valid).
//  Turns one burst request (dir, base, length) into consecutive single-word memory accesses.
//  Write bursts pull words over a valid/ready stream. Read bursts return words on a valid-only stream.
//  Sits between the accelerator/CPU datapath and the 4-bank word memory; one burst in flight at a time.
// PARAMETERS
//  LEN_W       16  width of burst length field (words); max burst 2**LEN_W-1
//  RD_LATENCY  1   cycles from mem_addr presented to mem_data_out valid (legal 1..4)
// PORTS
//  clk             in   1      system clock
//  rst             in   1      synchronous active-high reset
//  req_valid       in   1      burst request present
//  req_ready       out  1      master can accept request (IDLE only)
//  req_wr          in   1      1 = write burst, 0 = read burst
//  req_addr        in   32     byte base address; bits [1:0] ignored (word aligned)
//  req_len         in   LEN_W  burst length in words; 0 = empty burst
//  wdata           in   32     write word
//  wdata_valid     in   1      write word present
//  wdata_ready     out  1      write word consumed this cycle when valid&ready
//  rdata           out  32     read word
//  rdata_valid     out  1      read word valid, 1 cycle; no backpressure
//  busy            out  1      state != IDLE
//  done            out  1      1-cycle pulse at burst completion
//  err             out  1      sticky: read return sampled with mem_data_valid=0
//  mem_wr          out  1      memory write strobe
//  mem_addr        out  32     memory byte address (word aligned)
//  mem_data_in     out  32     memory write data
//  mem_data_out    in   32     memory read data
//  mem_data_valid  in   1      memory read data valid
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE.
//   All outputs 0, except req_ready=1 in the cycle after reset deasserts.
//   Read pipeline, counters and err cleared. In-flight burst abandoned; no done pulse.
//  States: IDLE, WRITE, READ, DRAIN, DONE.
//  IDLE: req_ready=1. On req_valid: latch dir, cur_addr={req_addr[31:2],2'b00}, remaining=req_len; clear err.
//   Next state is DONE if req_len==0, else WRITE (req_wr=1) or READ (req_wr=0).
//  WRITE: wdata_ready=1.
//   mem_wr=wdata_valid, mem_addr=cur_addr, mem_data_in=wdata (combinational from regs/inputs).
//   Each accepted beat: cur_addr+=4, remaining-=1. Last beat accepted -> DONE.
//   wdata_valid=0 cycles: mem_wr=0, address held.
//  READ: mem_wr=0, mem_addr=cur_addr. One read issued every cycle: cur_addr+=4, remaining-=1, outstanding+=1.
//   Last issue -> DRAIN.
//   Issue at cycle t: mem_data_out/mem_data_valid sampled at end of cycle t+RD_LATENCY.
//   The sample is registered, so rdata/rdata_valid appear in cycle t+RD_LATENCY+1. Beats arrive in issue order.
//   A sample with mem_data_valid=0 sets err. The beat is still emitted with whatever data is sampled.
//  DRAIN: no issue. Move to DONE in the cycle after the last rdata_valid (outstanding==0).
//  DONE: done=1 for exactly one cycle -> IDLE. busy=1 in WRITE/READ/DRAIN/DONE.
//  mem_wr=0 outside WRITE. mem_addr holds last value in IDLE/DRAIN/DONE.
//  Address arithmetic is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0x00000000 silently.
//  Read pipeline: shift register of RD_LATENCY valid bits; outstanding counter is LEN_W bits wide.
//  req_valid while busy is ignored (req_ready=0); the requester must hold it.
// TESTING
//  1 Write addr=0x100 len=4, wdata A0..A3 back-to-back.
//    -> mem_wr high 4 cycles at 0x100/0x104/0x108/0x10C with A0..A3; done the cycle after the last beat.
//  2 Read addr=0x100 len=4, RD_LATENCY=1, after test 1.
//    -> rdata A0..A3 on 4 consecutive cycles, first beat 2 cycles after first issue; done the cycle after the last beat; err=0.
//  3 Write len=3 with wdata_valid pattern 1,0,0,1,1.
//    -> mem_wr pattern 1,0,0,1,1; addresses 0x0,-,-,0x4,0x8; done after the 5th cycle.
//  4 req_len=0, either direction.
//    -> no mem_wr, no rdata_valid; done=1 the cycle after accept; req_ready=1 the cycle after that.
//  5 Read addr=0xFFFFFFFE len=2.
//    -> mem_addr 0xFFFFFFFC then 0x00000000; 2 beats; done.
//  6 Read len=8, rst pulsed during the 3rd beat.
//    -> rdata_valid=0, busy=0, req_ready=1 after reset; no done.
//    Repeat the read with mem_data_valid forced 0 on beat 2 -> err=1 held until the next request is accepted.

Source files
------------

// File: rtl/mem_burst_master.sv
// Burst initiator for the word-wide memory: turns one (dir, base, length) request into
// consecutive single-word accesses, fed by a valid/ready write stream, returning a valid-only read stream.
module mem_burst_master #(
    parameter int LEN_W      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [31:0]      wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data_in,
    input  logic [31:0]      mem_data_out,
    input  logic             mem_data_valid
);

    // Handshakes: a request or write word transfers in a cycle where valid&ready is high at the
    // rising edge; the sender holds its payload until then. rdata_valid has no backpressure.

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [31:0]           cur_addr;
    logic [31:0]           addr_hold;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      outstanding;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  accept;
    logic                  wr_beat;
    logic                  rd_issue;
    logic                  rd_sample;
    logic                  last;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    assign last      = (remaining == LEN_W'(1));
    assign accept    = (state == S_IDLE) && req_valid;
    assign wr_beat   = (state == S_WRITE) && wdata_valid;
    assign rd_issue  = (state == S_READ);
    assign rd_sample = rd_pipe[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        state_nxt = S_DONE;
                    end else if (req_wr) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wdata_valid && last) begin
                    state_nxt = S_DONE;
                end
            end
            S_READ: begin
                if (last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            addr_hold   <= '0;
            remaining   <= '0;
            outstanding <= '0;
            rd_pipe     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Valid bits march toward the sample point; data is captured only there.
            rd_pipe     <= RD_LATENCY'({rd_pipe, rd_issue});
            rdata_valid <= rd_sample;
            if (rd_sample) begin
                rdata <= mem_data_out;
            end
            if (accept) begin
                cur_addr  <= {req_addr[31:2], 2'b00};
                remaining <= req_len;
                err       <= 1'b0;
            end else begin
                if (wr_beat || rd_issue) begin
                    cur_addr  <= cur_addr + 32'd4;
                    remaining <= remaining - LEN_W'(1);
                end
                if (rd_sample && !mem_data_valid) begin
                    err <= 1'b1;
                end
            end
            if ((state == S_WRITE) || (state == S_READ)) begin
                addr_hold <= cur_addr;
            end
            if (rd_issue && !rd_sample) begin
                outstanding <= outstanding + LEN_W'(1);
            end else if (!rd_issue && rd_sample) begin
                outstanding <= outstanding - LEN_W'(1);
            end
        end
    end

    assign req_ready   = (state == S_IDLE) && !rst;
    assign wdata_ready = (state == S_WRITE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign mem_wr      = wr_beat;
    assign mem_data_in = (state == S_WRITE) ? wdata : '0;
    // Between bursts the bus shows the last address actually presented, not the advanced pointer.
    assign mem_addr    = ((state == S_WRITE) || (state == S_READ)) ? cur_addr : addr_hold;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: small word memory model, expected-read queue,
// one checking task, summary line at the end.
module tb_mem_burst_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_data_valid;

    int          n_checks;
    int          n_errors;
    string       cur_test;
    logic [31:0] exp_q[$];

    logic [31:0] mem [128];
    logic        mem_init;
    logic        kill_en;
    logic [31:0] kill_addr;

    mem_burst_master #(.LEN_W(16), .RD_LATENCY(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wdata          (wdata),
        .wdata_valid    (wdata_valid),
        .wdata_ready    (wdata_ready),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle registered read; mem_data_valid drops for a chosen address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hD000_0000 + 32'(i);
        end else if (mem_wr) begin
            mem[mem_addr[8:2]] <= mem_data_in;
        end
        mem_data_out   <= mem[mem_addr[8:2]];
        mem_data_valid <= !(kill_en && (mem_addr == kill_addr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL [%s] %s: got %h expected %h", cur_test, tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] base, input int len, input int ncyc,
                            input logic [7:0] vpat, input logic [31:0] dbase);
        int k;
        k = 0;
        next_cycle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = base; req_len = 16'(len);
        sample();
        check("req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < ncyc; i++) begin
            next_cycle();
            req_valid   = 1'b0;
            wdata_valid = vpat[i];
            wdata       = dbase + 32'(k);
            sample();
            check("mem_wr", 32'(mem_wr), 32'(vpat[i]));
            check("wdata_ready", 32'(wdata_ready), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (vpat[i]) begin
                check("mem_addr", mem_addr, {base[31:2], 2'b00} + 32'(4 * k));
                check("mem_data_in", mem_data_in, dbase + 32'(k));
                k++;
            end
        end
        next_cycle();
        wdata_valid = 1'b0;
        sample();
        check("done", 32'(done), 32'd1);
        check("mem_wr_done", 32'(mem_wr), 32'd0);
        next_cycle();
        sample();
        check("done_clr", 32'(done), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] base, input int len, input int kill_beat);
        int          beat;
        logic [31:0] a;
        logic [31:0] e;
        a = {base[31:2], 2'b00};
        next_cycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = base; req_len = 16'(len);
        kill_en   = (kill_beat >= 0);
        kill_addr = a + 32'(4 * kill_beat);
        sample();
        check("req_ready", 32'(req_ready), 32'd1);
        beat = 0;
        for (int i = 1; i <= len + 2; i++) begin
            next_cycle();
            req_valid = 1'b0;
            sample();
            check("mem_wr", 32'(mem_wr), 32'd0);
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (i <= len) check("mem_addr", mem_addr, a + 32'(4 * (i - 1)));
            if (i >= 3) begin
                check("rdata_valid", 32'(rdata_valid), 32'd1);
                e = exp_q.pop_front();
                if (beat != kill_beat) check("rdata", rdata, e);
                beat++;
            end else begin
                check("rdata_valid_idle", 32'(rdata_valid), 32'd0);
            end
        end
        next_cycle();
        sample();
        check("done", 32'(done), 32'd1);
        check("rdata_valid_done", 32'(rdata_valid), 32'd0);
        next_cycle();
        kill_en = 1'b0;
        sample();
        check("req_ready_after", 32'(req_ready), 32'd1);
        check("done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cur_test = "reset";
        rst = 1'b1; mem_init = 1'b1; kill_en = 1'b0; kill_addr = '0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wdata = '0; wdata_valid = 1'b0;
        repeat (3) next_cycle();
        sample();
        check("busy", 32'(busy), 32'd0);
        check("req_ready_in_rst", 32'(req_ready), 32'd0);
        check("done", 32'(done), 32'd0);
        check("rdata_valid", 32'(rdata_valid), 32'd0);
        check("mem_wr", 32'(mem_wr), 32'd0);
        check("err", 32'(err), 32'd0);
        check("mem_addr", mem_addr, 32'd0);
        next_cycle();
        rst = 1'b0; mem_init = 1'b0;
        sample();
        check("req_ready", 32'(req_ready), 32'd1);

        cur_test = "write4";
        do_write(32'h100, 4, 4, 8'b0000_1111, 32'hA0);

        cur_test = "read4";
        exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_read(32'h100, 4, -1);
        check("err", 32'(err), 32'd0);

        cur_test = "write_gaps";
        do_write(32'h0, 3, 5, 8'b0001_1001, 32'hB0);

        cur_test = "zero_len";
        next_cycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h40; req_len = 16'd0;
        sample();
        check("req_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("done", 32'(done), 32'd1);
        check("busy", 32'(busy), 32'd1);
        check("mem_wr", 32'(mem_wr), 32'd0);
        check("rdata_valid", 32'(rdata_valid), 32'd0);
        next_cycle();
        sample();
        check("req_ready_after", 32'(req_ready), 32'd1);
        check("done_clr", 32'(done), 32'd0);
        check("busy_clr", 32'(busy), 32'd0);

        cur_test = "addr_wrap";
        exp_q = {32'hD000_007F, 32'hB0};
        do_read(32'hFFFF_FFFE, 2, -1);

        cur_test = "reset_mid_read";
        exp_q = {32'hA0, 32'hA1, 32'hA2};
        next_cycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100; req_len = 16'd8;
        sample();
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            req_valid = 1'b0;
            if (i == 5) rst = 1'b1;
            sample();
            if (i >= 3) begin
                check("rdata_valid", 32'(rdata_valid), 32'd1);
                check("rdata", rdata, exp_q.pop_front());
            end
        end
        next_cycle();
        rst = 1'b0;
        sample();
        check("rdata_valid_rst", 32'(rdata_valid), 32'd0);
        check("busy_rst", 32'(busy), 32'd0);
        check("req_ready_rst", 32'(req_ready), 32'd1);
        check("mem_addr_rst", mem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
            check("no_done", 32'(done), 32'd0);
            check("no_rdata", 32'(rdata_valid), 32'd0);
        end

        cur_test = "read_err";
        exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3,
                 32'hD000_0044, 32'hD000_0045, 32'hD000_0046, 32'hD000_0047};
        do_read(32'h100, 8, 1);
        check("err_set", 32'(err), 32'd1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        next_cycle();
        sample();
        check("err_held", 32'(err), 32'd1);
        next_cycle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0; req_len = 16'd0;
        sample();
        check("err_at_accept", 32'(err), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("err_cleared", 32'(err), 32'd0);
        check("done", 32'(done), 32'd1);
        next_cycle();
        sample();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
